uc_multicycle: RTL
==================

// Module: uc_multicycle
// PURPOSE
//  Multicycle RISC-V control FSM: next generation of the core's control unit. Drives the same datapath strobes.
//  Adds B-type branches and LUI, and adds memory wait states with a timeout. Unknown opcodes trap instead of
//  defaulting to R-type. Sits between the IR opcode/funct3 fields plus ALU flags and the datapath mux/enable inputs.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles a memory access waits for mem_ready (>=1); counter width = $clog2(MEM_TIMEOUT+1)
//  TRAP_STICKY  1   1: TRAP held until reset; 0: TRAP lasts 1 cycle, then load_pc (pc+4) and go to FETCH
// PORTS
//  clk           in   1  clock, rising edge
//  reset         in   1  synchronous, active-high; wins over every other input
//  opcode        in   7  IR[6:0]
//  funct3        in   3  IR[14:12], branch condition select
//  alu_zero      in   1  ALU result == 0
//  alu_lt        in   1  signed rs1 < rs2
//  alu_ltu       in   1  unsigned rs1 < rs2
//  mem_ready     in   1  memory completes access this cycle (used only with UC_MEM_HANDSHAKE_EN)
//  WE_RF         out  1  register file write enable
//  WE_MEM        out  1  data memory write enable
//  RF_din_sel    out  2  00 mem, 01 ALU, 10 pc+4, 11 immediate (LUI)
//  ULA_din2_sel  out  1  0 rs2, 1 immediate
//  addr_sel      out  1  1 PC address, 0 ALU address
//  load_pc       out  1  PC register enable
//  load_ir       out  1  IR register enable
//  pc_next_sel   out  1  0 pc+4, 1 adder target
//  pc_adder_sel  out  1  1 PC-relative (JAL/branch), 0 rs1-relative (JALR)
//  mem_req       out  1  memory access active
//  illegal_instr out  1  in TRAP because of opcode/funct3
//  mem_fault     out  1  in TRAP because of memory timeout
//  state_dbg     out  5  current state encoding
// BEHAVIOUR
//  - Reset: state=FETCH, wait_cnt=0, br_taken_q=0, fault flags=0; outputs take FETCH values (addr_sel=1, mem_req=1,
//    all others 0 except load_ir, see below). Reset mid-instruction aborts it; there are no partial writes after the edge.
//  - Outputs are decoded from the state register (Moore), except load_ir/load_pc/WE_MEM in wait states (below).
//    Unlisted outputs are 0.
//  - FETCH: addr_sel=1, mem_req=1, load_ir=mem_ready; on mem_ready -> DECODE.
//  - DECODE: 0010011 EX_ADDI; 0110011 EX_ADDSUB; 0000011 EX_LOAD; 0100011 EX_STORE; 1101111 EX_JAL;
//    1100111 EX_JALR; 1100011 EX_BRANCH; 0110111 WB_LUI; any other opcode -> TRAP with illegal_instr.
//  - EX_x -> WB_x after 1 cycle, except EX_LOAD, which holds (mem_req=1, addr_sel=0, ULA_din2_sel=1) until mem_ready.
//  - WB_ADDSUB/ADDI/JAL/JALR: same strobes as EX plus WE_RF=1, load_pc=1. JAL pc_adder_sel=1; JALR pc_adder_sel=0.
//    Both JAL and JALR drive RF_din_sel=10 and pc_next_sel=1.
//  - WB_LOAD: RF_din_sel=00, addr_sel=0, ULA_din2_sel=1, WE_RF=1, load_pc=1.
//  - WB_STORE: WE_MEM=1, mem_req=1, addr_sel=0, ULA_din2_sel=1; holds until mem_ready; load_pc=mem_ready.
//  - WB_LUI: RF_din_sel=11, WE_RF=1, load_pc=1.
//  - EX_BRANCH: latch br_taken_q from funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
//    funct3 010/011 -> TRAP (illegal_instr).
//  - WB_BRANCH: load_pc=1, pc_adder_sel=1, pc_next_sel=br_taken_q; no RF write.
//  - Every WB state -> FETCH on the cycle load_pc=1.
//  - wait_cnt clears when a wait state is entered and increments each cycle mem_req=1 && !mem_ready.
//    mem_ready on waiting cycle N is accepted for N<=MEM_TIMEOUT. If cycle MEM_TIMEOUT ends with mem_ready=0,
//    the FSM goes to TRAP with mem_fault, and no RF/IR/PC write occurs.
//  - TRAP: all strobes 0, except when TRAP_STICKY=0 (load_pc=1, pc_next_sel=0, then FETCH). Flags clear on leaving TRAP.
// CONFIGURATION
//  UC_MEM_HANDSHAKE_EN defined: wait/timeout behaviour as above.
//  Not defined: mem_ready ignored and treated as 1. Every memory state lasts exactly 1 cycle. No wait_cnt logic.
//  mem_fault tied 0.
// TESTING
//  1. addi (0010011), mem_ready=1 always -> FETCH,DECODE,EX_ADDI,WB_ADDI; WE_RF=1 and load_pc=1 only in cycle 4.
//  2. beq, alu_zero=1 -> WB_BRANCH pc_next_sel=1; alu_zero=0 -> pc_next_sel=0; WE_RF=0 in both cases.
//  3. lw with mem_ready low 3 cycles in EX_LOAD -> EX_LOAD held 4 cycles, then WB_LOAD WE_RF=1 once.
//  4. sw with mem_ready never high, MEM_TIMEOUT=16 -> 16 WB_STORE cycles, then TRAP, mem_fault=1, load_pc never 1.
//  5. opcode 1111111 -> TRAP, illegal_instr=1 held (TRAP_STICKY=1); reset=1 -> FETCH next edge, flags 0.
//  6. reset asserted in EX_JAL -> next state FETCH, WE_RF never asserted for that JAL.

Source files
------------

// File: rtl/uc_multicycle.sv
// Multicycle RISC-V control FSM: Moore strobes decoded from the state register, plus memory wait states.
// Optional macro UC_MEM_HANDSHAKE_EN enables mem_ready wait states with a MEM_TIMEOUT trap.
module uc_multicycle #(
  parameter int MEM_TIMEOUT = 16,
  parameter bit TRAP_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       alu_ltu,
  input  logic       mem_ready,
  output logic       WE_RF,
  output logic       WE_MEM,
  output logic [1:0] RF_din_sel,
  output logic       ULA_din2_sel,
  output logic       addr_sel,
  output logic       load_pc,
  output logic       load_ir,
  output logic       pc_next_sel,
  output logic       pc_adder_sel,
  output logic       mem_req,
  output logic       illegal_instr,
  output logic       mem_fault,
  output logic [4:0] state_dbg
);

  typedef enum logic [4:0] {
    FETCH, DECODE,
    EX_ADDI, EX_ADDSUB, EX_LOAD, EX_STORE, EX_JAL, EX_JALR, EX_BRANCH,
    WB_ADDI, WB_ADDSUB, WB_LOAD, WB_STORE, WB_JAL, WB_JALR, WB_BRANCH, WB_LUI,
    TRAP
  } state_t;

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_t state_q, state_d;
  logic   brTaken_q, brTaken_d;
  logic   illegal_q, illegal_d;
  logic   memFault_q, memFault_d;
  logic   ready;
  logic   timeout;

`ifdef UC_MEM_HANDSHAKE_EN
  logic [CW-1:0] waitCnt_q, waitCnt_d;

  assign ready   = mem_ready;
  // Fires on the last accepted waiting cycle if memory still has not answered.
  assign timeout = !mem_ready && (waitCnt_q == CW'(MEM_TIMEOUT - 1));

  always_comb begin
    waitCnt_d = waitCnt_q;
    if (state_d != state_q)
      waitCnt_d = '0;
    else if (mem_req && !mem_ready)
      waitCnt_d = waitCnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) waitCnt_q <= '0;
    else       waitCnt_q <= waitCnt_d;
  end
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign ready   = 1'b1;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      brTaken_q  <= 1'b0;
      illegal_q  <= 1'b0;
      memFault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      brTaken_q  <= brTaken_d;
      illegal_q  <= illegal_d;
      memFault_q <= memFault_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    brTaken_d  = brTaken_q;
    illegal_d  = illegal_q;
    memFault_d = memFault_q;
    case (state_q)
      FETCH: begin
        if (ready) state_d = DECODE;
        else if (timeout) begin state_d = TRAP; memFault_d = 1'b1; end
      end
      DECODE: begin
        case (opcode)
          7'b0010011: state_d = EX_ADDI;
          7'b0110011: state_d = EX_ADDSUB;
          7'b0000011: state_d = EX_LOAD;
          7'b0100011: state_d = EX_STORE;
          7'b1101111: state_d = EX_JAL;
          7'b1100111: state_d = EX_JALR;
          7'b1100011: state_d = EX_BRANCH;
          7'b0110111: state_d = WB_LUI;
          default:    begin state_d = TRAP; illegal_d = 1'b1; end
        endcase
      end
      EX_ADDI:   state_d = WB_ADDI;
      EX_ADDSUB: state_d = WB_ADDSUB;
      EX_STORE:  state_d = WB_STORE;
      EX_JAL:    state_d = WB_JAL;
      EX_JALR:   state_d = WB_JALR;
      EX_LOAD: begin
        if (ready) state_d = WB_LOAD;
        else if (timeout) begin state_d = TRAP; memFault_d = 1'b1; end
      end
      EX_BRANCH: begin
        state_d = WB_BRANCH;
        case (funct3)
          3'b000:  brTaken_d = alu_zero;
          3'b001:  brTaken_d = !alu_zero;
          3'b100:  brTaken_d = alu_lt;
          3'b101:  brTaken_d = !alu_lt;
          3'b110:  brTaken_d = alu_ltu;
          3'b111:  brTaken_d = !alu_ltu;
          default: begin state_d = TRAP; illegal_d = 1'b1; end
        endcase
      end
      WB_STORE: begin
        if (ready) state_d = FETCH;
        else if (timeout) begin state_d = TRAP; memFault_d = 1'b1; end
      end
      WB_ADDI, WB_ADDSUB, WB_LOAD, WB_JAL, WB_JALR, WB_BRANCH, WB_LUI: state_d = FETCH;
      TRAP: begin
        if (!TRAP_STICKY) begin
          state_d    = FETCH;
          illegal_d  = 1'b0;
          memFault_d = 1'b0;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    WE_RF         = 1'b0;
    WE_MEM        = 1'b0;
    RF_din_sel    = 2'b00;
    ULA_din2_sel  = 1'b0;
    addr_sel      = 1'b0;
    load_pc       = 1'b0;
    load_ir       = 1'b0;
    pc_next_sel   = 1'b0;
    pc_adder_sel  = 1'b0;
    mem_req       = 1'b0;
    illegal_instr = 1'b0;
    mem_fault     = 1'b0;
    case (state_q)
      FETCH:     begin addr_sel = 1'b1; mem_req = 1'b1; load_ir = ready; end
      EX_ADDI:   begin RF_din_sel = 2'b01; ULA_din2_sel = 1'b1; end
      EX_ADDSUB: RF_din_sel = 2'b01;
      EX_LOAD:   begin mem_req = 1'b1; ULA_din2_sel = 1'b1; end
      EX_STORE:  ULA_din2_sel = 1'b1;
      EX_JAL:    begin RF_din_sel = 2'b10; pc_next_sel = 1'b1; pc_adder_sel = 1'b1; end
      EX_JALR:   begin RF_din_sel = 2'b10; pc_next_sel = 1'b1; end
      WB_ADDI:   begin RF_din_sel = 2'b01; ULA_din2_sel = 1'b1; WE_RF = 1'b1; load_pc = 1'b1; end
      WB_ADDSUB: begin RF_din_sel = 2'b01; WE_RF = 1'b1; load_pc = 1'b1; end
      WB_LOAD:   begin ULA_din2_sel = 1'b1; WE_RF = 1'b1; load_pc = 1'b1; end
      WB_STORE:  begin WE_MEM = 1'b1; mem_req = 1'b1; ULA_din2_sel = 1'b1; load_pc = ready; end
      WB_JAL: begin
        RF_din_sel = 2'b10; pc_next_sel = 1'b1; pc_adder_sel = 1'b1; WE_RF = 1'b1; load_pc = 1'b1;
      end
      WB_JALR:   begin RF_din_sel = 2'b10; pc_next_sel = 1'b1; WE_RF = 1'b1; load_pc = 1'b1; end
      WB_BRANCH: begin load_pc = 1'b1; pc_adder_sel = 1'b1; pc_next_sel = brTaken_q; end
      WB_LUI:    begin RF_din_sel = 2'b11; WE_RF = 1'b1; load_pc = 1'b1; end
      TRAP: begin
        illegal_instr = illegal_q;
        mem_fault     = memFault_q;
        load_pc       = !TRAP_STICKY;
      end
      default: ;
    endcase
  end

  assign state_dbg = state_q;

endmodule
